// File: rtl/c17_array_pipe_bist.sv
// -----------------------------------------------------------------------------
// c17_array_pipe_bist
//   CH parallel copies of the c17 six-NAND cell, split over two register
//   stages with a valid/ready handshake, plus a built-in self-test mode in
//   which a 32-bit LFSR feeds the array and a 32-bit MISR compacts the
//   results into a signature.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    in_data valid
//   in_ready    block accepts in_data this cycle
//   in_data     slice k bits [5k+4:5k] = {N7,N6,N3,N2,N1}
//   out_valid   out_data valid
//   out_ready   sink accepts out_data
//   out_data    slice k bits [2k+1:2k] = {N23,N22}
//   bist_start  one-cycle self-test start pulse
//   bist_busy   self-test injecting or draining
//   bist_done   self-test finished, signature valid
//   signature   MISR snapshot taken when the self-test finishes
// -----------------------------------------------------------------------------
module c17_array_pipe_bist #(
    parameter int          CH   = 2,
    parameter int          NPAT = 32,
    parameter logic [31:0] SEED = 32'hACE1_0001
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5*CH-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*CH-1:0] out_data,
    input  logic            bist_start,
    output logic            bist_busy,
    output logic            bist_done,
    output logic [31:0]     signature
);

    localparam int          IW        = 5 * CH;
    localparam int          OW        = 2 * CH;
    localparam int          S1W       = 4 * CH;
    localparam int          S2W       = 3 * CH;
    localparam logic [15:0] NPAT_LAST = 16'(NPAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Shift with taps 31,21,1,0; shared by the pattern generator and the MISR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] v, input logic [31:0] d);
        return lfsr_step(v) ^ d;
    endfunction

    // x = {N7,N6,N3,N2,N1} -> {N10,N11,N2,N7}
    function automatic logic [3:0] c17_stage1(input logic [4:0] x);
        return {~(x[0] & x[2]), ~(x[2] & x[3]), x[1], x[4]};
    endfunction

    // y = {N10,N11,N2,N7} -> {N10,N16,N19}
    function automatic logic [2:0] c17_stage2(input logic [3:0] y);
        return {y[3], ~(y[1] & y[2]), ~(y[2] & y[0])};
    endfunction

    // z = {N10,N16,N19} -> {N23,N22}
    function automatic logic [1:0] c17_out(input logic [2:0] z);
        return {~(z[1] & z[0]), ~(z[2] & z[1])};
    endfunction

    state_t           state_q, state_d;
    logic             s1_v_q, s1_v_d;
    logic [S1W-1:0]   s1_data_q, s1_data_d;
    logic             s2_v_q, s2_v_d;
    logic [S2W-1:0]   s2_data_q, s2_data_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [31:0]      misr_q, misr_d;
    logic [15:0]      pat_cnt_q, pat_cnt_d;
    logic             done_q, done_d;
    logic [31:0]      sig_q, sig_d;

    logic             bist_mode_s;
    logic             rdy_int_s;
    logic             adv1_s;
    logic             adv2_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             start_ok_s;
    logic [IW-1:0]    src_s;
    logic [OW-1:0]    out_data_s;

    // Handshake: in self-test the array never stalls on the external sink.
    always_comb begin
        bist_mode_s = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        rdy_int_s   = bist_mode_s ? 1'b1 : out_ready;
        adv2_s      = !s2_v_q || rdy_int_s;
        adv1_s      = !s1_v_q || adv2_s;
        in_ready_s  = adv1_s && (state_q == ST_IDLE) && !rst;
        accept_s    = in_valid && in_ready_s;
        start_ok_s  = bist_start && !s1_v_q && !s2_v_q;
        src_s       = (state_q == ST_RUN) ? lfsr_q[IW-1:0] : in_data;
    end

    // Combinational output slice from stage 2.
    always_comb begin
        out_data_s = '0;
        for (int k = 0; k < CH; k++) begin
            out_data_s[2*k +: 2] = c17_out(s2_data_q[3*k +: 3]);
        end
    end

    // Pipeline stage next-state: each stage loads only when it can advance.
    always_comb begin
        s1_v_d    = s1_v_q;
        s1_data_d = s1_data_q;
        s2_v_d    = s2_v_q;
        s2_data_d = s2_data_q;
        if (adv1_s) begin
            if (state_q == ST_RUN) begin
                s1_v_d = 1'b1;
            end else begin
                s1_v_d = accept_s;
            end
            for (int k = 0; k < CH; k++) begin
                s1_data_d[4*k +: 4] = c17_stage1(src_s[5*k +: 5]);
            end
        end else begin
            s1_v_d    = s1_v_q;
            s1_data_d = s1_data_q;
        end
        if (adv2_s) begin
            s2_v_d = s1_v_q;
            for (int k = 0; k < CH; k++) begin
                s2_data_d[3*k +: 3] = c17_stage2(s1_data_q[4*k +: 4]);
            end
        end else begin
            s2_v_d    = s2_v_q;
            s2_data_d = s2_data_q;
        end
    end

    // Self-test FSM, pattern generator and result compactor.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        pat_cnt_d = pat_cnt_q;
        done_d    = done_q;
        sig_d     = sig_q;
        // Every result leaving stage 2 during self-test is folded in.
        if (bist_mode_s && s2_v_q) begin
            misr_d = misr_step(misr_q, {{(32-OW){1'b0}}, out_data_s});
        end else begin
            misr_d = misr_q;
        end
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok_s) begin
                    state_d   = ST_RUN;
                    lfsr_d    = SEED;
                    misr_d    = 32'h0000_0000;
                    pat_cnt_d = 16'd0;
                    done_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                lfsr_d    = lfsr_step(lfsr_q);
                pat_cnt_d = pat_cnt_q + 16'd1;
                if (pat_cnt_q == NPAT_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Leave on the edge that empties the pipe so the final
                // compaction and the signature snapshot coincide.
                if (!s1_v_d && !s2_v_d) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    sig_d   = misr_d;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            s1_v_q    <= 1'b0;
            s1_data_q <= '0;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            lfsr_q    <= SEED;
            misr_q    <= 32'h0000_0000;
            pat_cnt_q <= 16'd0;
            done_q    <= 1'b0;
            sig_q     <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            s1_v_q    <= s1_v_d;
            s1_data_q <= s1_data_d;
            s2_v_q    <= s2_v_d;
            s2_data_q <= s2_data_d;
            lfsr_q    <= lfsr_d;
            misr_q    <= misr_d;
            pat_cnt_q <= pat_cnt_d;
            done_q    <= done_d;
            sig_q     <= sig_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_v_q && (state_q == ST_IDLE) && !rst;
    assign out_data  = out_data_s;
    assign bist_busy = bist_mode_s && !rst;
    assign bist_done = done_q && !rst;
    assign signature = rst ? 32'h0000_0000 : sig_q;

endmodule

// File: tb/tb_c17_array_pipe_bist.sv
// -----------------------------------------------------------------------------
// tb_c17_array_pipe_bist
//   Randomized bench for c17_array_pipe_bist (CH=2, NPAT=32). A capacity-two
//   scoreboard of golden c17 results predicts out_valid, in_ready and
//   out_data; a pure LFSR/MISR loop predicts the self-test signature. A second
//   instance with SEED=1 runs in lockstep.
// -----------------------------------------------------------------------------
module tb_c17_array_pipe_bist;

    localparam int          CH   = 2;
    localparam int          NPAT = 32;
    localparam logic [31:0] SEED = 32'hACE1_0001;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [5*CH-1:0] in_data;
    logic            out_ready;
    logic            bist_start;

    logic            in_ready, out_valid, bist_busy, bist_done;
    logic [2*CH-1:0] out_data;
    logic [31:0]     signature;

    logic            s1_in_ready, s1_out_valid, s1_bist_busy, s1_bist_done;
    logic [2*CH-1:0] s1_out_data;
    logic [31:0]     s1_signature;

    int              n_checks = 0;
    int              n_pass   = 0;
    int              cyc      = 0;
    logic [3:0]      q_exp[$];
    int              q_cyc[$];
    logic [3:0]      seen[$];
    logic            ir_seen;
    int              accepted;

    c17_array_pipe_bist #(.CH(CH), .NPAT(NPAT), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .bist_start(bist_start), .bist_busy(bist_busy),
        .bist_done(bist_done), .signature(signature)
    );

    c17_array_pipe_bist #(.CH(CH), .NPAT(NPAT), .SEED(32'h0000_0001)) dut_seed1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s1_in_ready),
        .in_data(in_data), .out_valid(s1_out_valid), .out_ready(out_ready),
        .out_data(s1_out_data), .bist_start(bist_start), .bist_busy(s1_bist_busy),
        .bist_done(s1_bist_done), .signature(s1_signature)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] c17_ref(input logic [4:0] x);
        logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
        {n7, n6, n3, n2, n1} = x;
        n10 = !(n1 && n3);
        n11 = !(n3 && n6);
        n16 = !(n2 && n11);
        n19 = !(n11 && n7);
        return {!(n16 && n19), !(n10 && n16)};
    endfunction

    function automatic logic [3:0] gold(input logic [9:0] d);
        return {c17_ref(d[9:5]), c17_ref(d[4:0])};
    endfunction

    function automatic logic [31:0] bist_model(input logic [31:0] seed);
        logic [31:0] lfsr = seed;
        logic [31:0] misr = 32'h0;
        for (int k = 0; k < NPAT; k++) begin
            misr = {misr[30:0], misr[31] ^ misr[21] ^ misr[1] ^ misr[0]} ^ {28'h0, gold(lfsr[9:0])};
            lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
        end
        return misr;
    endfunction

    // One functional cycle, entered and left at a falling edge.
    task automatic drive_cycle(input logic iv, input logic [9:0] d, input logic ordy);
        logic exp_ov;
        logic exp_ir;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        exp_ov = (q_exp.size() > 0) && (cyc >= q_cyc[0] + 2);
        exp_ir = (q_exp.size() < 2) || ordy;
        check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
        check_eq("in_ready", 32'(in_ready), 32'(exp_ir));
        check_eq("seed1_out_valid", 32'(s1_out_valid), 32'(exp_ov));
        check_eq("seed1_in_ready", 32'(s1_in_ready), 32'(exp_ir));
        ir_seen = in_ready;
        if (out_valid && ordy) begin
            if (q_exp.size() > 0) begin
                check_eq("out_data", 32'(out_data), 32'(q_exp[0]));
                check_eq("seed1_out_data", 32'(s1_out_data), 32'(q_exp[0]));
                seen.push_back(out_data);
                void'(q_exp.pop_front());
                void'(q_cyc.pop_front());
            end else begin
                check_eq("spurious_out", 32'(out_valid), 32'h0);
            end
        end
        if (iv && in_ready) begin
            q_exp.push_back(gold(d));
            q_cyc.push_back(cyc);
            accepted++;
        end
        @(negedge clk);
    endtask

    // Run one self-test from IDLE; returns busy cycles seen.
    task automatic run_bist(output int busy_cnt);
        int n;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        #1;
        busy_cnt = 0;
        n = 0;
        while (bist_busy && n < 200) begin
            busy_cnt++;
            if (n % 8 == 0) begin
                check_eq("bist_in_ready", 32'(in_ready), 32'h0);
                check_eq("bist_out_valid", 32'(out_valid), 32'h0);
            end
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
    endtask

    logic [31:0] sig_a;
    logic [31:0] sig_b;
    int          bc;
    int          n_seen;

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        bist_start = 1'b0;
        accepted   = 0;

        // 1: reset state
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'h0);
        check_eq("rst_in_ready", 32'(in_ready), 32'h0);
        check_eq("rst_busy", 32'(bist_busy), 32'h0);
        check_eq("rst_done", 32'(bist_done), 32'h0);
        check_eq("rst_signature", signature, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_eq("post_rst_in_ready", 32'(in_ready), 32'h1);
        check_eq("post_rst_out_valid", 32'(out_valid), 32'h0);
        @(negedge clk);

        // 2: single beat, two-cycle latency
        seen.delete();
        drive_cycle(1'b1, 10'b00000_11111, 1'b1);
        repeat (3) drive_cycle(1'b0, 10'h0, 1'b1);
        check_eq("single_count", 32'(seen.size()), 32'h1);
        if (seen.size() > 0) check_eq("single_data", 32'(seen[0]), 32'h1);

        // 3: back-pressure
        seen.delete();
        drive_cycle(1'b1, 10'b00010_00101, 1'b0);
        drive_cycle(1'b1, 10'b11111_00010, 1'b0);
        drive_cycle(1'b0, 10'h0, 1'b0);
        check_eq("in_ready_drop", 32'(ir_seen), 32'h0);
        drive_cycle(1'b0, 10'h0, 1'b0);
        repeat (4) drive_cycle(1'b0, 10'h0, 1'b1);
        check_eq("stall_count", 32'(seen.size()), 32'h2);
        if (seen.size() > 1) begin
            check_eq("stall_first", 32'(seen[0]), 32'hD);
            check_eq("stall_second", 32'(seen[1]), 32'h7);
        end

        // 4a: full-rate burst
        accepted = 0;
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, 10'($urandom), 1'b1);
        check_eq("burst_accepts", 32'(accepted), 32'd20);
        repeat (3) drive_cycle(1'b0, 10'h0, 1'b1);

        // 4b: random stream with random back-pressure
        accepted = 0;
        for (int i = 0; i < 2000 && accepted < 100; i++) begin
            drive_cycle($urandom_range(0, 3) != 0, 10'($urandom), 1'($urandom_range(0, 1)));
        end
        check_eq("stream_accepts", 32'(accepted), 32'd100);
        for (int i = 0; i < 20 && q_exp.size() > 0; i++) drive_cycle(1'b0, 10'h0, 1'b1);
        check_eq("stream_drained", 32'(q_exp.size()), 32'h0);

        // 5: self-test, rerun and alternate seed
        run_bist(bc);
        check_eq("bist_busy_cycles", 32'(bc), 32'(NPAT + 2));
        check_eq("bist_done", 32'(bist_done), 32'h1);
        check_eq("bist_signature", signature, bist_model(SEED));
        check_eq("seed1_signature", s1_signature, bist_model(32'h1));
        check_eq("seed1_done", 32'(s1_bist_done), 32'h1);
        check_eq("seed1_busy", 32'(s1_bist_busy), 32'h0);
        check_eq("seed_differs", 32'(s1_signature != signature), 32'h1);
        sig_a = signature;
        repeat (3) @(negedge clk);
        #1;
        check_eq("done_held", 32'(bist_done), 32'h1);
        check_eq("sig_held", signature, bist_model(SEED));
        check_eq("idle_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        run_bist(bc);
        sig_b = signature;
        check_eq("rerun_busy_cycles", 32'(bc), 32'(NPAT + 2));
        check_eq("rerun_signature", sig_b, sig_a);
        check_eq("rerun_model", sig_b, bist_model(SEED));
        repeat (2) @(negedge clk);

        // 6: reset in the middle of a run
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check_eq("midrun_busy", 32'(bist_busy), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("abort_busy", 32'(bist_busy), 32'h0);
        check_eq("abort_done", 32'(bist_done), 32'h0);
        check_eq("abort_out_valid", 32'(out_valid), 32'h0);
        check_eq("abort_signature", signature, 32'h0);
        check_eq("abort_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        n_seen = seen.size();
        drive_cycle(1'b1, 10'($urandom), 1'b1);
        repeat (4) drive_cycle(1'b0, 10'h0, 1'b1);
        check_eq("post_abort_beat", 32'(seen.size() - n_seen), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
